// File: rtl/free_addr_pool.sv
// Free-address pool: show-ahead circular FIFO of data-table addresses that
// self-fills with 0..DEPTH-1 after reset, then hands out and takes back addresses.
module free_addr_pool #(
  parameter int A_WIDTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  output logic [A_WIDTH-1:0] empty_addr_o,
  output logic               empty_addr_val_o,
  input  logic               empty_addr_rd_ack_i,
  input  logic [A_WIDTH-1:0] add_addr_i,
  input  logic               add_addr_val_i,
  output logic               add_addr_ready_o,
  output logic [A_WIDTH:0]   free_cnt_o,
  output logic               init_done_o,
  output logic               underflow_err_o,
  output logic               overflow_err_o
);

  localparam int               DEPTH     = 2**A_WIDTH;
  localparam logic [A_WIDTH:0] CNT_FULL  = (A_WIDTH+1)'(DEPTH);
  localparam logic [A_WIDTH-1:0] ADDR_LAST = A_WIDTH'(DEPTH-1);

  typedef enum logic {INIT_S, RUN_S} state_t;

  state_t             r_state;
  logic [A_WIDTH-1:0] r_mem [DEPTH];
  logic [A_WIDTH-1:0] r_rd_ptr;
  logic [A_WIDTH-1:0] r_wr_ptr;
  logic [A_WIDTH-1:0] r_init_addr;
  logic [A_WIDTH:0]   r_cnt;
  logic               r_underflow;
  logic               r_overflow;

  logic               w_run;
  logic               w_val;
  logic               w_pop;
  logic               w_push;
  logic               w_wr_en;
  logic [A_WIDTH-1:0] w_wr_data;

  assign w_run   = (r_state == RUN_S);
  assign w_val   = w_run && (r_cnt != '0);
  assign w_pop   = empty_addr_rd_ack_i && w_val;
  // A full pool still accepts a return when the head is popped in the same cycle.
  assign w_push  = add_addr_val_i && w_run && ((r_cnt != CNT_FULL) || w_pop);
  assign w_wr_en = !w_run || w_push;
  assign w_wr_data = w_run ? add_addr_i : r_init_addr;

  always_ff @(posedge clk_i) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_data;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= INIT_S;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_init_addr <= '0;
      r_cnt       <= '0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        INIT_S: begin
          r_init_addr <= r_init_addr + 1'b1;
          r_wr_ptr    <= r_wr_ptr + 1'b1;
          r_cnt       <= r_cnt + 1'b1;
          if (r_init_addr == ADDR_LAST) r_state <= RUN_S;
        end
        RUN_S: begin
          if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
          if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
          if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
          else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
          if (add_addr_val_i && (r_cnt == CNT_FULL) && !w_pop) r_overflow <= 1'b1;
        end
      endcase
      if (empty_addr_rd_ack_i && !w_val) r_underflow <= 1'b1;
    end
  end

  assign empty_addr_o     = r_mem[r_rd_ptr];
  assign empty_addr_val_o = w_val;
  assign add_addr_ready_o = w_run;
  assign free_cnt_o       = r_cnt;
  assign init_done_o      = w_run;
  assign underflow_err_o  = r_underflow;
  assign overflow_err_o   = r_overflow;

endmodule

// File: tb/tb_free_addr_pool.sv
// Bench for free_addr_pool: directed steps plus random traffic, all compared
// every cycle against a queue-based model of the pool.
module tb_free_addr_pool;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic [AW-1:0] empty_addr_o;
  logic          empty_addr_val_o;
  logic          empty_addr_rd_ack_i = 1'b0;
  logic [AW-1:0] add_addr_i = '0;
  logic          add_addr_val_i = 1'b0;
  logic          add_addr_ready_o;
  logic [AW:0]   free_cnt_o;
  logic          init_done_o;
  logic          underflow_err_o;
  logic          overflow_err_o;

  free_addr_pool #(.A_WIDTH(AW)) dut (
    .clk_i               (clk_i),
    .rst_n_i             (rst_n_i),
    .empty_addr_o        (empty_addr_o),
    .empty_addr_val_o    (empty_addr_val_o),
    .empty_addr_rd_ack_i (empty_addr_rd_ack_i),
    .add_addr_i          (add_addr_i),
    .add_addr_val_i      (add_addr_val_i),
    .add_addr_ready_o    (add_addr_ready_o),
    .free_cnt_o          (free_cnt_o),
    .init_done_o         (init_done_o),
    .underflow_err_o     (underflow_err_o),
    .overflow_err_o      (overflow_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pool contents as a plain queue, init as a cycle count.
  int q[$];
  bit m_init;
  int m_icnt;
  bit m_uf;
  bit m_of;

  task automatic model_reset();
    q.delete();
    m_init = 1'b1;
    m_icnt = 0;
    m_uf   = 1'b0;
    m_of   = 1'b0;
  endtask

  task automatic model_step(input bit ack, input bit val, input int addr);
    bit has;
    bit pop;
    bit room;
    if (m_init) begin
      if (ack) m_uf = 1'b1;
      q.push_back(m_icnt);
      m_icnt++;
      if (m_icnt == DEPTH) m_init = 1'b0;
    end else begin
      has  = (q.size() != 0);
      pop  = ack && has;
      room = (q.size() < DEPTH) || pop;
      if (ack && !has) m_uf = 1'b1;
      if (pop) void'(q.pop_front());
      if (val) begin
        if (room) q.push_back(addr);
        else      m_of = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    bit exp_val;
    exp_val = !m_init && (q.size() != 0);
    check({tag, ".done"},  32'(init_done_o),      32'(!m_init));
    check({tag, ".ready"}, 32'(add_addr_ready_o), 32'(!m_init));
    check({tag, ".val"},   32'(empty_addr_val_o), 32'(exp_val));
    check({tag, ".cnt"},   32'(free_cnt_o),       32'(q.size()));
    check({tag, ".uf"},    32'(underflow_err_o),  32'(m_uf));
    check({tag, ".of"},    32'(overflow_err_o),   32'(m_of));
    if (exp_val) check({tag, ".head"}, 32'(empty_addr_o), 32'(q[0]));
  endtask

  task automatic cycle(input string tag, input bit ack, input bit val, input logic [AW-1:0] addr);
    empty_addr_rd_ack_i = ack;
    add_addr_val_i      = val;
    add_addr_i          = addr;
    @(posedge clk_i);
    model_step(ack, val, int'(addr));
    #1;
    compare_all(tag);
  endtask

  initial begin
    model_reset();
    #2;
    compare_all("reset");
    @(negedge clk_i);
    rst_n_i = 1'b1;

    for (int i = 0; i < DEPTH - 1; i++) begin
      cycle("init", 1'b0, 1'b0, '0);
      check("init.val_low", 32'(empty_addr_val_o), 32'd0);
    end
    cycle("init_last", 1'b0, 1'b0, '0);
    check("init.head0",  32'(empty_addr_o), 32'd0);
    check("init.cnt16",  32'(free_cnt_o),   32'd16);
    check("init.done",   32'(init_done_o),  32'd1);

    cycle("full_push_ack", 1'b1, 1'b1, 4'd5);
    check("full_push_ack.head", 32'(empty_addr_o),   32'd1);
    check("full_push_ack.cnt",  32'(free_cnt_o),     32'd16);
    check("full_push_ack.of",   32'(overflow_err_o), 32'd0);

    cycle("full_push", 1'b0, 1'b1, 4'd5);
    check("full_push.of",  32'(overflow_err_o), 32'd1);
    check("full_push.cnt", 32'(free_cnt_o),     32'd16);

    for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b1, 1'b0, '0);
    check("drain.cnt", 32'(free_cnt_o),       32'd0);
    check("drain.val", 32'(empty_addr_val_o), 32'd0);
    check("drain.uf",  32'(underflow_err_o),  32'd0);

    cycle("ack17", 1'b1, 1'b0, '0);
    check("ack17.uf",  32'(underflow_err_o), 32'd1);
    check("ack17.cnt", 32'(free_cnt_o),      32'd0);

    cycle("push7", 1'b0, 1'b1, 4'd7);
    check("push7.val",  32'(empty_addr_val_o), 32'd1);
    check("push7.head", 32'(empty_addr_o),     32'd7);
    cycle("push3", 1'b0, 1'b1, 4'd3);
    cycle("pop7", 1'b1, 1'b0, '0);
    check("pop7.head", 32'(empty_addr_o), 32'd3);

    for (int i = 0; i < 3; i++) begin
      cycle("hold", 1'b0, 1'b1, AW'(9 + i));
      check("hold.head", 32'(empty_addr_o), 32'd3);
      check("hold.cnt",  32'(free_cnt_o),   32'(2 + i));
    end

    for (int i = 0; i < 200; i++)
      cycle("rnd_fill", $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 65, AW'($urandom_range(0, DEPTH - 1)));
    for (int i = 0; i < 200; i++)
      cycle("rnd_drain", $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 30, AW'($urandom_range(0, DEPTH - 1)));
    for (int i = 0; i < 200; i++)
      cycle("rnd_mix", $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 50, AW'($urandom_range(0, DEPTH - 1)));

    rst_n_i = 1'b0;
    #1;
    model_reset();
    compare_all("rst_run");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < 8; i++) cycle("reinit", 1'b0, 1'b0, '0);
    rst_n_i = 1'b0;
    #1;
    model_reset();
    compare_all("rst_init8");
    check("rst_init8.cnt", 32'(free_cnt_o), 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) cycle("reinit2", 1'b0, 1'b0, '0);
    check("reinit2.head", 32'(empty_addr_o), 32'd0);
    check("reinit2.cnt",  32'(free_cnt_o),   32'd16);
    for (int i = 0; i < 3; i++) begin
      cycle("reinit_pop", 1'b1, 1'b0, '0);
      check("reinit_pop.head", 32'(empty_addr_o), 32'(i + 1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
